adc_sample_scheduler: RTL and testbench
=======================================

ADC_SAMPLE_SCHEDULER -- requirements
Module: adc_sample_scheduler

Interface
REQ-001 Parameter ADC_RES, default 8, sample width in bits.
REQ-002 Parameter PERIOD_W, default 16, width of the sample-period register.
REQ-003 Parameter FIFO_DEPTH, default 8 (power of two), sample buffer depth.
REQ-004 Parameter TIMEOUT_TICKS, default 255, max clocks to wait for conversion-complete.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  high = periodic sampling runs.
REQ-008 period  in  PERIOD_W  clocks between capture starts; values 0 and 1 behave as 2.
REQ-009 startCapture  out  1  active-low capture request to the ADC driver.
REQ-010 conversionComplete  in  1  active-low completion from the ADC driver.
REQ-011 adcData  in  ADC_RES  driver result; valid while conversionComplete is low.
REQ-012 rdEn  in  1  pop one sample.
REQ-013 rdData  out  ADC_RES  popped sample, registered.
REQ-014 empty / full  out  1 each  FIFO status.
REQ-015 count  out  log2(FIFO_DEPTH)+1  samples held.
REQ-016 overrun / missedTick / timeoutErr  out  1 each  sticky error flags.
REQ-017 clrErr  in  1  synchronous clear of all sticky flags.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT_TICK, REQ, ACK.
- IDLE: startCapture=1, timer held at 0; enable=1 -> WAIT_TICK, timer loaded with max(period,2)-1.
REQ-019 WAIT_TICK SHALL decrement the timer; at 0 -> REQ, startCapture=0, timer reloaded.
REQ-020 The timer SHALL free-run (reload at 0) in REQ and ACK; tick at 0 outside WAIT_TICK SHALL set missedTick. The tick is dropped, not queued.
REQ-021 REQ SHALL hold startCapture=0 until conversionComplete=0 is sampled.
- Then latch adcData, push into FIFO, -> ACK with startCapture=1.
REQ-022 REQ SHALL count clocks; after TIMEOUT_TICKS clocks without conversionComplete=0 -> ACK, startCapture=1, timeoutErr=1, no push.
REQ-023 ACK SHALL wait for conversionComplete=1.
- Then enable=1 -> WAIT_TICK (timer not reloaded); enable=0 -> IDLE.
REQ-024 Deasserting enable during REQ or ACK SHALL NOT abort the handshake; the block returns to IDLE after ACK completes.
REQ-025 Push when full and rdEn=0 SHALL drop the sample and set overrun.
- Push when full with rdEn=1 in the same cycle: both succeed, count unchanged.
REQ-026 rdEn with empty=1 SHALL be ignored; rdData holds its value.
REQ-027 rdEn with empty=0 SHALL present the oldest sample on rdData the next cycle.
REQ-028 Simultaneous push and pop when not empty and not full: count unchanged.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; empty = (count==0), full = (count==FIFO_DEPTH).
REQ-030 clrErr coincident with a setting event: the set SHALL win.

Reset
REQ-031 Reset SHALL be asynchronous on reset=1 and released synchronously.
REQ-032 Reset values: state=IDLE, startCapture=1, rdData=0, count=0, empty=1, full=0, overrun=0, missedTick=0, timeoutErr=0, timer=0, pointers=0.
REQ-033 Reset mid-handshake SHALL return startCapture to 1 immediately.
- On release, the block SHALL wait in IDLE for enable; it requires no driver state.

Structure
REQ-034 ADC_RES, default FIFO_DEPTH, TIMEOUT_TICKS and the FSM state encoding SHALL live in a shared adc_pkg package.
REQ-035 The buffer SHALL be a sub-module sample_fifo (synchronous, registered read, count/full/empty outputs).
- The FSM, period timer and timeout counter stay in the top module.

Verification
REQ-036 period=10, enable=1, driver model completes 4 clk after request:
- startCapture falls every 10 clk;
- values 0x11, 0x22, 0x33 arrive in order;
- count=3.
REQ-037 9 captures with no reads (FIFO_DEPTH=8) -> full=1 after the 8th, 9th dropped, overrun=1; clrErr -> overrun=0.
REQ-038 Driver never asserts conversionComplete -> startCapture rises after 255 clk in REQ, timeoutErr=1, count unchanged.
REQ-039 period=3, driver completes after 8 clk -> missedTick=1, no extra startCapture pulse.
REQ-040 FIFO full, push and rdEn in the same cycle -> count stays 8, oldest sample on rdData next cycle, overrun=0.
REQ-041 Reset asserted while startCapture=0 -> startCapture=1 asynchronously, all flags 0, empty=1; no activity until enable.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared defaults and FSM encoding for the ADC sample scheduler.
package adc_pkg;

    localparam int unsigned ADC_RES_DEFAULT       = 8;
    localparam int unsigned PERIOD_W_DEFAULT      = 16;
    localparam int unsigned FIFO_DEPTH_DEFAULT    = 8;
    localparam int unsigned TIMEOUT_TICKS_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        REQ       = 2'd2,
        ACK       = 2'd3
    } schedState_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample buffer with registered read data and registered status flags.
module sample_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wrEn,
    input  logic [DATA_W-1:0]        wrData,
    input  logic                     rdEn,
    output logic [DATA_W-1:0]        rdData,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic              doPush;
    logic              doPop;
    logic [CNT_W-1:0]  countNext;

    // A pop frees a slot in the same cycle, so a full buffer can still accept a push.
    always_comb begin
        doPop     = 1'b0;
        doPush    = 1'b0;
        countNext = count;
        doPop     = rdEn && !empty;
        doPush    = wrEn && (!full || doPop);
        if (doPush && !doPop) begin
            countNext = count + CNT_W'(1);
        end else if (doPop && !doPush) begin
            countNext = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            rdData <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr  <= rdPtr + PTR_W'(1);
                rdData <= mem[rdPtr];
            end
            count <= countNext;
            empty <= (countNext == '0);
            full  <= (countNext == CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Periodic ADC capture scheduler: period timer, request/ack handshake with timeout,
// and a sample buffer with sticky error flags.
module adc_sample_scheduler
    import adc_pkg::*;
#(
    parameter int unsigned ADC_RES       = ADC_RES_DEFAULT,
    parameter int unsigned PERIOD_W      = PERIOD_W_DEFAULT,
    parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEFAULT,
    parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [PERIOD_W-1:0]           period,
    output logic                          startCapture,
    input  logic                          conversionComplete,
    input  logic [ADC_RES-1:0]            adcData,
    input  logic                          rdEn,
    output logic [ADC_RES-1:0]            rdData,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overrun,
    output logic                          missedTick,
    output logic                          timeoutErr,
    input  logic                          clrErr
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);

    schedState_t         state;
    logic [PERIOD_W-1:0] timer;
    logic [PERIOD_W-1:0] reloadVal;
    logic [TO_W-1:0]     toCnt;
    logic [1:0]          rstSync;
    logic                rstInt;
    logic                push;
    logic                overrunSet;

    // Asserts immediately with reset, releases two clocks after reset drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstSync <= 2'b11;
        end else begin
            rstSync <= {rstSync[0], 1'b0};
        end
    end
    assign rstInt = rstSync[1];

    assign reloadVal  = (period < PERIOD_W'(2)) ? PERIOD_W'(1) : period - PERIOD_W'(1);
    assign push       = (state == REQ) && !conversionComplete;
    assign overrunSet = push && full && !rdEn;

    always_ff @(posedge clk or posedge rstInt) begin
        if (rstInt) begin
            state        <= IDLE;
            startCapture <= 1'b1;
            timer        <= '0;
            toCnt        <= '0;
            overrun      <= 1'b0;
            missedTick   <= 1'b0;
            timeoutErr   <= 1'b0;
        end else begin
            if (clrErr) begin
                overrun    <= 1'b0;
                missedTick <= 1'b0;
                timeoutErr <= 1'b0;
            end
            if (overrunSet) begin
                overrun <= 1'b1;
            end
            // The timer keeps running through the handshake; a tick landing there is lost.
            if (state == REQ || state == ACK) begin
                if (timer == '0) begin
                    timer      <= reloadVal;
                    missedTick <= 1'b1;
                end else begin
                    timer <= timer - PERIOD_W'(1);
                end
            end
            case (state)
                IDLE: begin
                    startCapture <= 1'b1;
                    timer        <= '0;
                    if (enable) begin
                        state <= WAIT_TICK;
                        timer <= reloadVal;
                    end
                end
                WAIT_TICK: begin
                    if (!enable) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer == '0) begin
                        state        <= REQ;
                        startCapture <= 1'b0;
                        timer        <= reloadVal;
                        toCnt        <= '0;
                    end else begin
                        timer <= timer - PERIOD_W'(1);
                    end
                end
                REQ: begin
                    if (!conversionComplete) begin
                        state        <= ACK;
                        startCapture <= 1'b1;
                    end else if (toCnt == TO_W'(TIMEOUT_TICKS - 1)) begin
                        state        <= ACK;
                        startCapture <= 1'b1;
                        timeoutErr   <= 1'b1;
                    end else begin
                        toCnt <= toCnt + TO_W'(1);
                    end
                end
                ACK: begin
                    if (conversionComplete) begin
                        if (enable) begin
                            state <= WAIT_TICK;
                        end else begin
                            state <= IDLE;
                            timer <= '0;
                        end
                    end
                end
            endcase
        end
    end

    sample_fifo #(
        .DATA_W (ADC_RES),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (rstInt),
        .wrEn   (push),
        .wrData (adcData),
        .rdEn   (rdEn),
        .rdData (rdData),
        .empty  (empty),
        .full   (full),
        .count  (count)
    );

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler: period/handshake table, buffer corner sequences,
// timeout and reset sequences, and a randomized run against a queue model.
module tb_adc_sample_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] period = 16'd10;
    logic        startCapture;
    logic        conversionComplete = 1'b1;
    logic [7:0]  adcData = 8'h00;
    logic        rdEn = 1'b0;
    logic [7:0]  rdData;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        overrun;
    logic        missedTick;
    logic        timeoutErr;
    logic        clrErr = 1'b0;

    int   nChecks = 0;
    int   nFails  = 0;
    int   cyc     = 0;

    int   drvDelay = 4;
    bit   drvNever = 1'b0;
    logic [7:0] drvVal  = 8'h11;
    logic [7:0] drvStep = 8'h11;
    int   drvAge  = 0;

    typedef struct {
        logic [15:0] period;
        int          delay;
        int          expInterval;
        bit          expMissed;
    } vec_t;

    vec_t vecs[7];

    adc_sample_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .period             (period),
        .startCapture       (startCapture),
        .conversionComplete (conversionComplete),
        .adcData            (adcData),
        .rdEn               (rdEn),
        .rdData             (rdData),
        .empty              (empty),
        .full               (full),
        .count              (count),
        .overrun            (overrun),
        .missedTick         (missedTick),
        .timeoutErr         (timeoutErr),
        .clrErr             (clrErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // ADC driver: answers a request drvDelay clocks after it sees startCapture low.
    always @(negedge clk) begin
        if (reset) begin
            conversionComplete = 1'b1;
            drvAge = 0;
        end else if (!conversionComplete) begin
            if (startCapture) conversionComplete = 1'b1;
        end else if (!startCapture && !drvNever) begin
            drvAge++;
            if (drvAge >= drvDelay) begin
                conversionComplete = 1'b0;
                adcData = drvVal;
                drvVal  = drvVal + drvStep;
                drvAge  = 0;
            end
        end else begin
            drvAge = 0;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic boundFail(input string name, input int budget);
        nChecks++;
        nFails++;
        $display("FAIL %s: event not seen within %0d cycles", name, budget);
    endtask

    task automatic waitFall(input string name, input int budget, output int at);
        logic last;
        bit   found;
        last  = startCapture;
        found = 1'b0;
        at    = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(posedge clk); #1;
            if (last && !startCapture) begin
                found = 1'b1;
                at    = cyc;
            end
            last = startCapture;
        end
        if (!found) boundFail(name, budget);
    endtask

    task automatic doReset();
        reset  = 1'b1;
        enable = 1'b0;
        rdEn   = 1'b0;
        clrErr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic quietCheck(input string name, input int cycles);
        bit saw;
        saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (!startCapture) saw = 1'b1;
        end
        chk(name, saw, 0);
    endtask

    task automatic popCheck(input string name, input int exp);
        @(negedge clk);
        rdEn = 1'b1;
        @(posedge clk); #1;
        chk(name, rdData, exp);
        @(negedge clk);
        rdEn = 1'b0;
    endtask

    initial begin
        int f1, f2, f3, t0, t1;
        bit found;
        bit [7:0] mq[$];
        logic [7:0] mRd;
        bit mOvr;
        bit doPop;
        int rdPct;

        // interval = smallest multiple of max(period,2) that is >= delay+2
        vecs[0] = '{16'd10, 4, 10, 1'b0};
        vecs[1] = '{16'd3,  8, 12, 1'b1};
        vecs[2] = '{16'd0,  1, 4,  1'b1};
        vecs[3] = '{16'd1,  1, 4,  1'b1};
        vecs[4] = '{16'd5,  2, 5,  1'b0};
        vecs[5] = '{16'd4,  2, 4,  1'b0};
        vecs[6] = '{16'd4,  3, 8,  1'b1};

        doReset();
        chk("rst_startCapture", startCapture, 1);
        chk("rst_rdData", rdData, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_flags", {overrun, missedTick, timeoutErr}, 0);

        // Period / handshake table; enable dropped mid-handshake after the third request.
        for (int v = 0; v < 7; v++) begin
            doReset();
            period   = vecs[v].period;
            drvDelay = vecs[v].delay;
            drvVal   = 8'h11;
            drvStep  = 8'h11;
            @(negedge clk);
            enable = 1'b1;
            waitFall($sformatf("v%0d_fall1", v), 60, f1);
            waitFall($sformatf("v%0d_fall2", v), 60, f2);
            waitFall($sformatf("v%0d_fall3", v), 60, f3);
            enable = 1'b0;
            chk($sformatf("v%0d_interval12", v), f2 - f1, vecs[v].expInterval);
            chk($sformatf("v%0d_interval23", v), f3 - f2, vecs[v].expInterval);
            repeat (vecs[v].delay + 4) @(posedge clk);
            #1;
            chk($sformatf("v%0d_count", v), count, 3);
            chk($sformatf("v%0d_missedTick", v), missedTick, vecs[v].expMissed);
            quietCheck($sformatf("v%0d_idleQuiet", v), 30);
            for (int i = 0; i < 3; i++)
                popCheck($sformatf("v%0d_pop%0d", v, i), (17 * (i + 1)) & 255);
            chk($sformatf("v%0d_emptyAfterPops", v), empty, 1);
        end

        // Fill to full, drop the ninth, clear, then push+pop on a full buffer.
        doReset();
        period = 16'd6; drvDelay = 2; drvVal = 8'd1; drvStep = 8'd1;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 1; k <= 8; k++) waitFall($sformatf("ovr_fall%0d", k), 40, f1);
        repeat (4) @(posedge clk);
        #1;
        chk("ovr_full8", full, 1);
        chk("ovr_count8", count, 8);
        chk("ovr_notYet", overrun, 0);
        waitFall("ovr_fall9", 40, f1);
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("ovr_set", overrun, 1);
        chk("ovr_countHeld", count, 8);
        @(negedge clk); clrErr = 1'b1;
        @(negedge clk); clrErr = 1'b0;
        chk("ovr_cleared", overrun, 0);
        enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk); #1;
            if (!conversionComplete) found = 1'b1;
        end
        if (!found) boundFail("fullPushPop_wait", 40);
        rdEn = 1'b1;
        enable = 1'b0;
        @(posedge clk); #1;
        chk("fullPushPop_count", count, 8);
        chk("fullPushPop_rdData", rdData, 1);
        chk("fullPushPop_overrun", overrun, 0);
        chk("fullPushPop_full", full, 1);
        @(negedge clk); rdEn = 1'b0;
        for (int i = 0; i < 8; i++)
            popCheck($sformatf("drain%0d", i), (i < 7) ? i + 2 : 10);
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);
        popCheck("emptyRead_hold", 10);
        chk("emptyRead_count", count, 0);

        // Driver never answers: timeout, then reset in the middle of the next request.
        doReset();
        drvNever = 1'b1; period = 16'd10;
        @(negedge clk);
        enable = 1'b1;
        waitFall("to_fall", 40, t0);
        found = 1'b0;
        t1 = -1;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk); #1;
            if (startCapture) begin
                found = 1'b1;
                t1 = cyc;
            end
        end
        if (!found) boundFail("to_rise", 300);
        chk("to_latency", t1 - t0, 255);
        chk("to_timeoutErr", timeoutErr, 1);
        chk("to_count", count, 0);
        chk("to_missedTick", missedTick, 1);
        waitFall("to_fall2", 40, f1);
        repeat (5) @(posedge clk);
        #2;
        chk("preReset_startCapture", startCapture, 0);
        reset = 1'b1;
        #1;
        chk("asyncRst_startCapture", startCapture, 1);
        chk("asyncRst_flags", {overrun, missedTick, timeoutErr}, 0);
        chk("asyncRst_empty", empty, 1);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drvNever = 1'b0;
        quietCheck("postRst_quiet", 30);
        chk("postRst_count", count, 0);

        // Randomized run against a queue model of the buffer.
        doReset();
        mq.delete();
        mRd = 8'h00;
        mOvr = 1'b0;
        drvVal = 8'($urandom);
        drvStep = 8'd37;
        for (int seg = 0; seg < 3; seg++) begin
            period   = 16'($urandom_range(4, 12));
            drvDelay = $urandom_range(1, 6);
            rdPct    = (seg == 0) ? 5 : (seg == 1) ? 30 : 60;
            enable   = 1'b1;
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                rdEn   = ($urandom_range(0, 99) < rdPct);
                clrErr = ($urandom_range(0, 49) == 0);
                @(posedge clk);
                doPop = rdEn && (mq.size() > 0);
                if (clrErr) mOvr = 1'b0;
                if (doPop) mRd = mq.pop_front();
                if (!conversionComplete) begin
                    if (mq.size() < 8) mq.push_back(adcData);
                    else mOvr = 1'b1;
                end
                #1;
                chk("rnd_count", count, mq.size());
                chk("rnd_empty", empty, mq.size() == 0);
                chk("rnd_full", full, mq.size() == 8);
                chk("rnd_rdData", rdData, mRd);
                chk("rnd_overrun", overrun, mOvr);
            end
        end
        @(negedge clk);
        rdEn = 1'b0;
        clrErr = 1'b0;
        enable = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
